// File: rtl/pattern_stream_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first for a requested
// number of repetitions, with GAP idle cycles between repetitions and a one-cycle Done pulse.
module pattern_stream_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [CNT_W-1:0] Repeat,
    output logic             Serial,
    output logic             Valid,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Rep_Left
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [CNT_W-1:0] r_rep_left;
    logic             r_serial;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [CNT_W-1:0] w_rep_load;

    assign w_accept   = Start && ((r_state == StIdle) || (r_state == StDone));
    assign w_rep_load = (Repeat == '0) ? CNT_W'(1) : Repeat;

    // r_idx always names the bit currently presented on Serial.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= StIdle;
            r_pat      <= '0;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_rep_left <= '0;
            r_serial   <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        r_state    <= StSend;
                        r_pat      <= Pattern;
                        r_idx      <= IDX_MAX;
                        r_gap_cnt  <= '0;
                        r_rep_left <= w_rep_load;
                        r_serial   <= Pattern[WIDTH-1];
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end else begin
                        r_state    <= StIdle;
                        r_rep_left <= '0;
                        r_serial   <= 1'b0;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b0;
                    end
                end
                StSend: begin
                    if (r_idx != '0) begin
                        r_idx    <= r_idx - 1'b1;
                        r_serial <= r_pat[r_idx - 1'b1];
                    end else if (r_rep_left > CNT_W'(1)) begin
                        r_rep_left <= r_rep_left - 1'b1;
                        r_idx      <= IDX_MAX;
                        if (GAP == 0) begin
                            r_serial <= r_pat[WIDTH-1];
                        end else begin
                            r_state   <= StGap;
                            r_gap_cnt <= GAP_LOAD;
                            r_serial  <= 1'b0;
                            r_valid   <= 1'b0;
                        end
                    end else begin
                        r_state    <= StDone;
                        r_rep_left <= '0;
                        r_serial   <= 1'b0;
                        r_valid    <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == '0) begin
                        r_state  <= StSend;
                        r_serial <= r_pat[WIDTH-1];
                        r_valid  <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign Serial   = r_serial;
    assign Valid    = r_valid;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Rep_Left = r_rep_left;

endmodule

// File: tb/tb_pattern_stream_tx.sv
// Bench for pattern_stream_tx: a GAP=2 and a GAP=0 instance share stimulus and are checked every
// cycle against a cycle-index reference model, plus a directed table and hand-written corner cases.
module tb_pattern_stream_tx;

    localparam int W = 8;

    logic       Clock   = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start   = 1'b0;
    logic [7:0] Pattern = 8'h00;
    logic [3:0] Repeat  = 4'h0;

    logic       ser [2];
    logic       val [2];
    logic       bsy [2];
    logic       dn  [2];
    logic [3:0] rl  [2];

    pattern_stream_tx #(.WIDTH(8), .GAP(2), .CNT_W(4)) u_dut_g2 (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Serial(ser[0]), .Valid(val[0]), .Busy(bsy[0]), .Done(dn[0]), .Rep_Left(rl[0])
    );

    pattern_stream_tx #(.WIDTH(8), .GAP(0), .CNT_W(4)) u_dut_g0 (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Serial(ser[1]), .Valid(val[1]), .Busy(bsy[1]), .Done(dn[1]), .Rep_Left(rl[1])
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic       serial;
        logic       valid;
        logic       busy;
        logic       done;
        logic [3:0] rep;
    } out_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] rep;
        bit         noise;
        int         done_g2;
        int         done_g0;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: transaction active flag, cycle index k since acceptance, latched values.
    bit         act  [2];
    int         k    [2];
    logic [7:0] mpat [2];
    int         mn   [2];
    out_t       e_o  [2];
    out_t       g_o  [2];

    function automatic int gap_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int total_of(int d);
        return mn[d] * W + (mn[d] - 1) * gap_of(d);
    endfunction

    function automatic out_t exp_out(int d);
        out_t o;
        int   per, r, j;
        o = '0;
        if (!act[d]) return o;
        if (k[d] < total_of(d)) begin
            per    = W + gap_of(d);
            r      = k[d] / per;
            j      = k[d] % per;
            o.busy = 1'b1;
            if (j < W) begin
                o.valid  = 1'b1;
                o.serial = mpat[d][W-1-j];
                o.rep    = 4'(mn[d] - r);
            end else begin
                o.rep = 4'(mn[d] - r - 1);
            end
        end else begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            act[0] = 1'b0;
            act[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if ((!act[d] || k[d] == total_of(d)) && Start === 1'b1) begin
                    act[d]  = 1'b1;
                    k[d]    = 0;
                    mpat[d] = Pattern;
                    mn[d]   = (Repeat == 4'h0) ? 1 : int'(Repeat);
                end else if (act[d]) begin
                    k[d]++;
                    if (k[d] > total_of(d)) act[d] = 1'b0;
                end
            end
        end
    end

    always @(negedge Clock) begin
        for (int d = 0; d < 2; d++) begin
            e_o[d] = exp_out(d);
            g_o[d] = {ser[d], val[d], bsy[d], dn[d], rl[d]};
            n_vec++;
            if (g_o[d] !== e_o[d]) begin
                n_bad++;
                $display("FAIL stream gap%0d t=%0t: got ser=%b val=%b busy=%b done=%b rep=%0d, want ser=%b val=%b busy=%b done=%b rep=%0d",
                         gap_of(d), $time, g_o[d].serial, g_o[d].valid, g_o[d].busy,
                         g_o[d].done, g_o[d].rep, e_o[d].serial, e_o[d].valid, e_o[d].busy,
                         e_o[d].done, e_o[d].rep);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int d0, d1;
        d0 = -1;
        d1 = -1;
        @(negedge Clock);
        Pattern = v.pat;
        Repeat  = v.rep;
        Start   = 1'b1;
        for (int c = 0; c < 200 && (d0 < 0 || d1 < 0); c++) begin
            @(negedge Clock);
            if (dn[0] && d0 < 0) d0 = c;
            if (dn[1] && d1 < 0) d1 = c;
            if (v.noise && c < 7) begin
                Start   = 1'($urandom_range(0, 1));
                Pattern = 8'($urandom);
            end else begin
                Start = 1'b0;
            end
        end
        Start = 1'b0;
        check({name, " done cycle gap2"}, d0, v.done_g2);
        check({name, " done cycle gap0"}, d1, v.done_g0);
        repeat (2) @(negedge Clock);
    endtask

    vec_t tbl [6];

    initial begin
        int   first_done, second_done, v9;
        bit   seen;
        tbl[0] = '{pat: 8'hB2, rep: 4'd1, noise: 1'b0, done_g2: 8,  done_g0: 8};
        tbl[1] = '{pat: 8'hA5, rep: 4'd3, noise: 1'b0, done_g2: 28, done_g0: 24};
        tbl[2] = '{pat: 8'h3C, rep: 4'd0, noise: 1'b0, done_g2: 8,  done_g0: 8};
        tbl[3] = '{pat: 8'h5A, rep: 4'd2, noise: 1'b1, done_g2: 18, done_g0: 16};
        tbl[4] = '{pat: 8'hC3, rep: 4'd1, noise: 1'b1, done_g2: 8,  done_g0: 8};
        tbl[5] = '{pat: 8'h81, rep: 4'd4, noise: 1'b0, done_g2: 38, done_g0: 32};

        repeat (3) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (10) @(negedge Clock);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Start held high: transmissions separated by exactly one Done cycle.
        first_done  = -1;
        second_done = -1;
        v9          = -1;
        @(negedge Clock);
        Pattern = 8'hFF;
        Repeat  = 4'd1;
        Start   = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (dn[0]) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 9) v9 = int'(val[0]);
        end
        Start = 1'b0;
        check("b2b first done", first_done, 8);
        check("b2b second done", second_done, 17);
        check("b2b valid cycle 9", v9, 1);
        repeat (12) @(negedge Clock);

        // Reset in the middle of cycle 4 aborts with no Done pulse.
        @(negedge Clock);
        Pattern = 8'hA5;
        Repeat  = 4'd3;
        Start   = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        repeat (4) @(negedge Clock);
        check("abort busy before reset", int'(bsy[0]), 1);
        #1 Reset_n = 1'b0;
        #1;
        check("abort outputs gap2", int'({ser[0], val[0], bsy[0], dn[0], rl[0]}), 0);
        check("abort outputs gap0", int'({ser[1], val[1], bsy[1], dn[1], rl[1]}), 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        seen    = 1'b0;
        repeat (40) begin
            @(negedge Clock);
            seen = seen | dn[0] | dn[1];
        end
        check("abort no done", int'(seen), 0);

        // Random traffic against the reference model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge Clock);
            Start   = ($urandom_range(0, 5) == 0);
            Pattern = 8'($urandom);
            Repeat  = ($urandom_range(0, 30) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        end
        Start = 1'b0;
        repeat (200) @(negedge Clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
